// File: rtl/cnn_pkg.sv
`default_nettype none
// =============================================================================
// Module   : cnn_pkg
// Brief    : Shared widths, FSM state encoding and ReLU/saturation helper for
//            the convolution write path.
// Revision : 1.0
// =============================================================================
package cnn_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 18;
    localparam int DIM_W  = 9;
    localparam int K_W    = 10;
    localparam int N_MAX  = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Works on a 64-bit sign-extended value so it serves any ACC_W/OUT_W pair.
    function automatic logic signed [63:0] relu_sat(
        input logic signed [63:0] v,
        input int                 out_w,
        input logic               relu_en
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r  = v;
        if (relu_en && (v < 64'sd0)) begin
            r = 64'sd0;
        end
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_out_writer_if.sv
`default_nettype none
// =============================================================================
// Module   : conv_out_writer_if
// Brief    : Operand stream (pixel/weight pairs) and output-RAM write port.
// Revision : 1.0
// =============================================================================
interface conv_out_writer_if #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int OUT_W  = cnn_pkg::OUT_W,
    parameter int ADDR_W = cnn_pkg::ADDR_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] pix_data;
    logic signed [DATA_W-1:0] wt_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [OUT_W-1:0]  wr_data;

    modport master (
        output in_valid, pix_data, wt_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, pix_data, wt_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/conv_out_writer_mac.sv
`default_nettype none
// =============================================================================
// Module   : conv_mac
// Brief    : Signed multiply-accumulate with clear/enable and a registered
//            ReLU + saturation output stage.
// Revision : 1.0
// =============================================================================
module conv_mac #(
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int ACC_W   = cnn_pkg::ACC_W,
    parameter int OUT_W   = cnn_pkg::OUT_W,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] pix,
    input  logic signed [DATA_W-1:0] wt,
    output logic signed [OUT_W-1:0]  result
);
    import cnn_pkg::*;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_acc_nxt;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [OUT_W-1:0]    r_result;

    assign w_prod    = pix * wt;
    assign w_acc_nxt = r_acc + ACC_W'(w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (clr) begin
                r_acc <= '0;
            end else if (en) begin
                r_acc <= w_acc_nxt;
            end
            // The result is taken from the sum including the final product,
            // so it is ready in the same cycle the write strobe rises.
            if (load) begin
                r_result <= OUT_W'(relu_sat(64'(w_acc_nxt), OUT_W, (RELU_EN != 0)));
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: rtl/conv_out_writer.sv
`default_nettype none
// =============================================================================
// Module   : conv_out_writer
// Brief    : Accumulates one kernel window of operand pairs and writes the
//            post-processed result to the output map in raster order.
// Revision : 1.0
// =============================================================================
module conv_out_writer #(
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int ACC_W   = cnn_pkg::ACC_W,
    parameter int OUT_W   = cnn_pkg::OUT_W,
    parameter int RELU_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [cnn_pkg::DIM_W-1:0] ht_sm,
    input  logic [cnn_pkg::DIM_W-1:0] wt_sm,
    input  logic [cnn_pkg::DIM_W-1:0] ht_lg,
    input  logic [cnn_pkg::DIM_W-1:0] wt_lg,
    conv_out_writer_if.slave          bus,
    output logic                      busy,
    output logic                      layer_done,
    output logic                      cfg_err
);
    import cnn_pkg::*;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2*DIM_W-1:0]  w_n;
    logic                w_geom_ok;
    logic                w_start_ok;
    logic                w_last_k;
    logic                w_more_x;
    logic                w_more_y;
    logic [ADDR_W-1:0]   w_addr;
    logic [K_W-1:0]      r_k;
    logic [K_W-1:0]      r_n_m1;
    logic [DIM_W-1:0]    r_ox;
    logic [DIM_W-1:0]    r_oy;
    logic [DIM_W-1:0]    r_ow;
    logic [DIM_W-1:0]    r_oh;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_cfg_err;
    logic                w_mac_clr;
    logic                w_mac_en;
    logic                w_mac_load;
    logic                w_in_ready;
    logic                w_wr_en;
    logic                w_busy;
    logic                w_layer_done;
    logic signed [OUT_W-1:0] w_result;

    assign w_n       = ht_sm * wt_sm;
    assign w_geom_ok = (ht_sm != '0) && (wt_sm != '0) &&
                       (wt_sm <= wt_lg) && (ht_sm <= ht_lg) &&
                       (w_n <= (2*DIM_W)'(N_MAX));
    assign w_start_ok = (r_state == IDLE) && start && w_geom_ok;
    assign w_last_k   = (r_k == r_n_m1);
    assign w_more_x   = (r_ox < (r_ow - 1'b1));
    assign w_more_y   = (r_oy < (r_oh - 1'b1));
    assign w_addr     = ADDR_W'(r_ox) + ADDR_W'(r_oy) * ADDR_W'(r_ow);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_in_ready   = 1'b0;
        w_wr_en      = 1'b0;
        w_busy       = 1'b0;
        w_layer_done = 1'b0;
        w_mac_clr    = 1'b0;
        w_mac_en     = 1'b0;
        w_mac_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_mac_clr   = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (bus.in_valid) begin
                    w_mac_en = 1'b1;
                    if (w_last_k) begin
                        w_mac_load  = 1'b1;
                        w_state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                w_wr_en     = 1'b1;
                w_busy      = 1'b1;
                w_mac_clr   = 1'b1;
                w_state_nxt = (w_more_x || w_more_y) ? ACCUM : FIN;
            end
            FIN: begin
                w_layer_done = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= '0;
            r_n_m1    <= '0;
            r_ox      <= '0;
            r_oy      <= '0;
            r_ow      <= '0;
            r_oh      <= '0;
            r_wr_addr <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == IDLE) && start && !w_geom_ok;
            if (w_start_ok) begin
                r_n_m1 <= K_W'(w_n - 1'b1);
                r_ow   <= wt_lg - wt_sm + 1'b1;
                r_oh   <= ht_lg - ht_sm + 1'b1;
                r_k    <= '0;
                r_ox   <= '0;
                r_oy   <= '0;
            end
            if (w_mac_en) begin
                r_k <= r_k + 1'b1;
            end
            if (w_mac_load) begin
                r_wr_addr <= w_addr;
            end
            if (w_wr_en) begin
                r_k <= '0;
                if (w_more_x) begin
                    r_ox <= r_ox + 1'b1;
                end else if (w_more_y) begin
                    r_ox <= '0;
                    r_oy <= r_oy + 1'b1;
                end
            end
        end
    end

    conv_mac #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .RELU_EN (RELU_EN)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_mac_clr),
        .en     (w_mac_en),
        .load   (w_mac_load),
        .pix    (bus.pix_data),
        .wt     (bus.wt_data),
        .result (w_result)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = w_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = w_result;
    assign busy         = w_busy;
    assign layer_done   = w_layer_done;
    assign cfg_err      = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_out_writer.sv
`default_nettype none
// =============================================================================
// Module   : tb_conv_out_writer
// Brief    : Scoreboard bench driving one stream into a RELU_EN=0 and a
//            RELU_EN=1 instance of conv_out_writer.
// Revision : 1.0
// =============================================================================
module tb_conv_out_writer;

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [8:0]        ht_sm, wt_sm, ht_lg, wt_lg;
    logic              tb_valid;
    logic signed [7:0] tb_pix, tb_wt;
    logic              busy0, done0, err0, busy1, done1, err1;

    exp_t q0[$];
    exp_t q1[$];
    int   wr_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   layer_t0 = 0;

    conv_out_writer_if bus0 ();
    conv_out_writer_if bus1 ();

    assign bus0.in_valid = tb_valid;
    assign bus0.pix_data = tb_pix;
    assign bus0.wt_data  = tb_wt;
    assign bus1.in_valid = tb_valid;
    assign bus1.pix_data = tb_pix;
    assign bus1.wt_data  = tb_wt;

    conv_out_writer #(.RELU_EN(0)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .ht_sm(ht_sm), .wt_sm(wt_sm), .ht_lg(ht_lg), .wt_lg(wt_lg),
        .bus(bus0.slave), .busy(busy0), .layer_done(done0), .cfg_err(err0)
    );

    conv_out_writer #(.RELU_EN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .ht_sm(ht_sm), .wt_sm(wt_sm), .ht_lg(ht_lg), .wt_lg(wt_lg),
        .bus(bus1.slave), .busy(busy1), .layer_done(done1), .cfg_err(err1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    // Advance one clock, then pop and compare any write either instance made.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus0.wr_en === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_cnt++;
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected_relu0: got addr=%0d data=%0d, required no write",
                         bus0.wr_addr, bus0.wr_data);
            end else begin
                e = q0.pop_front();
                if ({bus0.wr_addr, bus0.wr_data} !== {e.addr, e.data}) begin
                    bad++;
                    $display("FAIL wr_relu0: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             bus0.wr_addr, bus0.wr_data, e.addr, $signed(e.data));
                end
            end
        end
        if (bus1.wr_en === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected_relu1: got addr=%0d data=%0d, required no write",
                         bus1.wr_addr, bus1.wr_data);
            end else begin
                e = q1.pop_front();
                if ({bus1.wr_addr, bus1.wr_data} !== {e.addr, e.data}) begin
                    bad++;
                    $display("FAIL wr_relu1: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             bus1.wr_addr, bus1.wr_data, e.addr, $signed(e.data));
                end
            end
        end
    endtask

    task automatic get_op(input int mode, input int idx,
                          output logic signed [7:0] p, output logic signed [7:0] w);
        case (mode)
            0: case (idx % 4)
                   0: begin p = 8'(3);  w = 8'(4); end
                   1: begin p = 8'(-2); w = 8'(5); end
                   2: begin p = 8'(7);  w = 8'(7); end
                   default: begin p = 8'(-1); w = 8'(1); end
               endcase
            1: begin p = 8'(1); w = 8'(1); end
            2: begin
                   if (idx == 0) begin p = 8'(-10); w = 8'(10); end
                   else begin p = 8'(1); w = 8'(1); end
               end
            3: begin p = 8'(127);  w = 8'(127); end
            4: begin p = 8'(-128); w = 8'(127); end
            default: begin p = 8'($urandom_range(0, 255)); w = 8'($urandom_range(0, 255)); end
        endcase
    endtask

    // Drives a whole layer; abort_at >= 0 stops before that operand index.
    task automatic run_layer(input int hs, input int ws, input int hl, input int wl,
                             input int mode, input bit gap, input bit poke_start,
                             input int abort_at);
        int n, nwin, idx, guard;
        longint acc;
        logic signed [7:0] p, w;
        exp_t e0, e1;
        bit poked;
        n = hs * ws;
        nwin = (hl - hs + 1) * (wl - ws + 1);
        ht_sm = 9'(hs); wt_sm = 9'(ws); ht_lg = 9'(hl); wt_lg = 9'(wl);
        tb_valid = 1'b0;
        start = 1'b1;
        layer_t0 = cyc;
        step();
        start = 1'b0;
        total++;
        if (err0 !== 1'b0 || busy0 !== 1'b1 || busy1 !== 1'b1) begin
            bad++;
            $display("FAIL start_accept: got cfg_err=%b busy=%b, required cfg_err=0 busy=1", err0, busy0);
        end
        idx = 0;
        poked = 1'b0;
        for (int win = 0; win < nwin; win++) begin
            acc = 0;
            for (int k = 0; k < n; k++) begin
                if (idx == abort_at) return;
                guard = 0;
                while (bus0.in_ready !== 1'b1 && guard < 8) begin
                    tb_valid = 1'b0;
                    step();
                    guard++;
                end
                if (bus0.in_ready !== 1'b1) begin
                    total++;
                    bad++;
                    $display("FAIL in_ready_timeout: got in_ready=%b, required 1", bus0.in_ready);
                    return;
                end
                if (gap) begin
                    tb_valid = 1'b0;
                    if (poke_start && !poked && win == 1) begin
                        start = 1'b1;
                        ht_sm = 9'd1;
                        wt_sm = 9'd1;
                        poked = 1'b1;
                    end
                    step();
                    start = 1'b0;
                end
                get_op(mode, idx, p, w);
                acc += longint'(p) * longint'(w);
                if (k == n - 1) begin
                    e0.addr = 18'(win);
                    e0.data = sat16(acc);
                    e1.addr = 18'(win);
                    e1.data = sat16((acc < 0) ? 0 : acc);
                    q0.push_back(e0);
                    q1.push_back(e1);
                end
                tb_pix = p;
                tb_wt = w;
                tb_valid = 1'b1;
                step();
                idx++;
            end
        end
        tb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tb_valid = 1'b0; tb_pix = '0; tb_wt = '0;
        ht_sm = '0; wt_sm = '0; ht_lg = '0; wt_lg = '0;
        step();
        step();
        total++;
        if ({bus0.in_ready, bus0.wr_en, busy0, done0, err0, bus1.in_ready, bus1.wr_en, busy1, done1, err1} !== 10'b0
            || bus0.wr_addr !== 18'd0 || bus0.wr_data !== 16'sd0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b wr=%b busy=%b done=%b err=%b addr=%0d data=%0d, required all 0",
                     bus0.in_ready, bus0.wr_en, busy0, done0, err0, bus0.wr_addr, bus0.wr_data);
        end
        rst = 1'b0;
        step();
        total++;
        if (bus0.in_ready !== 1'b0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got rdy=%b busy=%b, required 0 0", bus0.in_ready, busy0);
        end
    endtask

    task automatic test_pairs_1x1();
        int w0;
        w0 = wr_cnt;
        run_layer(2'd1, 1, 2, 2, 0, 1'b0, 1'b0, -1);
        step();
        total++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || done1 !== 1'b1) begin
            bad++;
            $display("FAIL pairs_done: got done=%b busy=%b, required done=1 busy=0", done0, busy0);
        end
        step();
        total++;
        if (done0 !== 1'b0 || q0.size() != 0 || q1.size() != 0 || wr_cnt - w0 != 4) begin
            bad++;
            $display("FAIL pairs_drain: got done=%b pending=%0d/%0d writes=%0d, required 0 0/0 4",
                     done0, q0.size(), q1.size(), wr_cnt - w0);
        end
    endtask

    task automatic test_timing_2x2();
        wr_cyc.delete();
        run_layer(2, 2, 3, 3, 1, 1'b0, 1'b0, -1);
        total++;
        if (busy0 !== 1'b1 || bus0.wr_en !== 1'b1) begin
            bad++;
            $display("FAIL timing_last_write: got busy=%b wr_en=%b, required 1 1", busy0, bus0.wr_en);
        end
        step();
        total++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL timing_done: got done=%b busy=%b, required done=1 busy=0", done0, busy0);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_cyc.size() <= i || wr_cyc[i] - layer_t0 != 5 * (i + 1)) begin
                bad++;
                $display("FAIL timing_write_cycle%0d: got %0d, required %0d", i,
                         (wr_cyc.size() > i) ? wr_cyc[i] - layer_t0 : -1, 5 * (i + 1));
            end
        end
        step();
    endtask

    task automatic test_relu();
        run_layer(1, 2, 1, 2, 2, 1'b0, 1'b0, -1);
        step();
        total++;
        if (done0 !== 1'b1 || done1 !== 1'b1) begin
            bad++;
            $display("FAIL relu_done: got done=%b/%b, required 1/1", done0, done1);
        end
        step();
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL relu_drain: got pending=%0d/%0d, required 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic test_saturation();
        for (int m = 3; m <= 4; m++) begin
            run_layer(3, 3, 3, 3, m, 1'b0, 1'b0, -1);
            step();
            total++;
            if (done0 !== 1'b1 || busy0 !== 1'b0) begin
                bad++;
                $display("FAIL sat_done_mode%0d: got done=%b busy=%b, required 1 0", m, done0, busy0);
            end
            step();
            total++;
            if (q0.size() != 0 || q1.size() != 0) begin
                bad++;
                $display("FAIL sat_drain_mode%0d: got pending=%0d/%0d, required 0/0", m, q0.size(), q1.size());
            end
        end
    endtask

    task automatic test_gap_restart();
        int w0;
        w0 = wr_cnt;
        run_layer(2, 2, 3, 3, 1, 1'b1, 1'b1, -1);
        step();
        total++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL gap_done: got done=%b busy=%b, required 1 0", done0, busy0);
        end
        step();
        total++;
        if (q0.size() != 0 || wr_cnt - w0 != 4) begin
            bad++;
            $display("FAIL gap_drain: got pending=%0d writes=%0d, required 0 4", q0.size(), wr_cnt - w0);
        end
    endtask

    task automatic test_random();
        int w0;
        w0 = wr_cnt;
        run_layer(3, 2, 5, 4, 5, 1'b0, 1'b0, -1);
        step();
        total++;
        if (done0 !== 1'b1) begin
            bad++;
            $display("FAIL random_done: got done=%b, required 1", done0);
        end
        step();
        total++;
        if (q0.size() != 0 || q1.size() != 0 || wr_cnt - w0 != 9) begin
            bad++;
            $display("FAIL random_drain: got pending=%0d/%0d writes=%0d, required 0/0 9",
                     q0.size(), q1.size(), wr_cnt - w0);
        end
    endtask

    task automatic test_max_kernel();
        run_layer(31, 33, 31, 33, 1, 1'b0, 1'b0, -1);
        step();
        total++;
        if (done0 !== 1'b1 || q0.size() != 0) begin
            bad++;
            $display("FAIL maxk_done: got done=%b pending=%0d, required 1 0", done0, q0.size());
        end
        step();
    endtask

    task automatic test_cfg_err();
        int cases [4][4] = '{'{2, 5, 4, 4}, '{0, 3, 4, 4}, '{32, 32, 40, 40}, '{5, 2, 4, 8}};
        int w0;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            ht_sm = 9'(cases[i][0]); wt_sm = 9'(cases[i][1]);
            ht_lg = 9'(cases[i][2]); wt_lg = 9'(cases[i][3]);
            start = 1'b1;
            step();
            start = 1'b0;
            total++;
            if (err0 !== 1'b1 || err1 !== 1'b1 || busy0 !== 1'b0 || bus0.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL cfg_err_pulse%0d: got err=%b busy=%b rdy=%b, required 1 0 0",
                         i, err0, busy0, bus0.in_ready);
            end
            step();
            total++;
            if (err0 !== 1'b0 || busy0 !== 1'b0) begin
                bad++;
                $display("FAIL cfg_err_clear%0d: got err=%b busy=%b, required 0 0", i, err0, busy0);
            end
        end
        total++;
        if (wr_cnt != w0) begin
            bad++;
            $display("FAIL cfg_err_nowrite: got writes=%0d, required 0", wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        bit seen_done;
        run_layer(2, 2, 3, 3, 1, 1'b0, 1'b0, 6);
        tb_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({bus0.in_ready, bus0.wr_en, busy0, done0} !== 4'b0 || bus0.wr_addr !== 18'd0
            || bus0.wr_data !== 16'sd0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got rdy=%b wr=%b busy=%b done=%b addr=%0d data=%0d, required all 0",
                     bus0.in_ready, bus0.wr_en, busy0, done0, bus0.wr_addr, bus0.wr_data);
        end
        w0 = wr_cnt;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done0 === 1'b1) seen_done = 1'b1;
        end
        total++;
        if (seen_done || wr_cnt != w0) begin
            bad++;
            $display("FAIL rst_mid_quiet: got layer_done_seen=%b writes=%0d, required 0 0", seen_done, wr_cnt - w0);
        end
        run_layer(2, 2, 3, 3, 1, 1'b0, 1'b0, -1);
        step();
        total++;
        if (done0 !== 1'b1 || q0.size() != 0 || wr_cnt - w0 != 4) begin
            bad++;
            $display("FAIL rst_mid_rerun: got done=%b pending=%0d writes=%0d, required 1 0 4",
                     done0, q0.size(), wr_cnt - w0);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_pairs_1x1();
        test_timing_2x2();
        test_relu();
        test_saturation();
        test_gap_restart();
        test_random();
        test_max_kernel();
        test_cfg_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by 1 ms, required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
